meriac_morse_sequencer: RTL and testbench
=========================================

Name: meriac_morse_sequencer

Overview:
Playback controller for the 2-bit Morse symbol database (meriac_morse_db). It drives the database address, fetches one symbol at a time, and converts each symbol into correctly timed key-on/key-off intervals plus a gated square-wave tone. It supports start, stop and loop control, and sits between the top-level io pins and the symbol ROM.

Parameters:
ADDR_W, 9, width of db_addr; the database depth is 2**ADDR_W.
UNIT_CYCLES, 5424, clk cycles per Morse time unit (>=2).
TONE_HALF, 8, clk cycles per tone half-period (>=1).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
start  input  1  begin playback from address 0; ignored while busy
stop  input  1  abort playback; takes priority over start
loop_en  input  1  sampled at end-of-message: 1 = replay, 0 = finish
db_addr  output  ADDR_W  registered symbol address to the database
db_sym  input  2  combinational database data for db_addr
key  output  1  Morse keying, 1 = mark
tone  output  1  square-wave audio; 0 whenever key=0
busy  output  1  1 in any state other than IDLE
done  output  1  one-cycle pulse on normal message end

Behaviour:
- Clock is clk. Reset is asynchronous and active-low. While reset=0: state=IDLE, db_addr=0, key=0, tone=0, busy=0, done=0, and all counters are cleared. The effect is immediate and needs no clock edge.
- Symbol codes: 00 END, 01 DIT, 10 DAH, 11 GAP.
- Every DIT/DAH is followed automatically by 1 unit of space. GAP adds 2 units, so a letter gap is 3 units. The database encodes a word gap as three consecutive GAPs (1+2+2+2 = 7 units).
- States: IDLE, FETCH, MARK, SPACE.
- IDLE: start=1 and stop=0 -> FETCH with db_addr=0.
- FETCH (exactly 1 cycle; db_addr has been stable for the whole cycle), samples db_sym:
  - DIT -> MARK for 1 unit.
  - DAH -> MARK for 3 units.
  - GAP -> SPACE for 2 units, db_addr+1.
  - END with loop_en=1 -> SPACE for 7 units, db_addr=0.
  - END with loop_en=0 -> IDLE, done=1 for one cycle, db_addr=0.
- MARK: key=1. At the end of the last unit -> SPACE for 1 unit, db_addr+1.
- SPACE: key=0. At the end of the last unit -> FETCH.
- Timing: a prescaler counts 0..UNIT_CYCLES-1 and is cleared on every entry to MARK or SPACE. A unit counter is loaded on entry and decrements at prescaler terminal count. An interval of n units lasts exactly n*UNIT_CYCLES cycles.
- key is registered. It rises on the same edge that enters MARK and falls on the edge that leaves MARK.
- db_addr increments modulo 2**ADDR_W. Wrapping from the top address to 0 is silent: playback continues and done is not raised.
- stop=1 in any state: next edge -> IDLE, key=0, tone=0, db_addr=0, done stays 0, and all counters clear.
- start while busy is ignored. start and stop asserted in the same cycle resolve to stop.
- loop_en is only evaluated in FETCH on an END symbol. Changing it mid-message has no other effect.
- tone: a divider runs only while key=1 and toggles tone every TONE_HALF cycles. The divider and tone are forced to 0 while key=0, so each mark starts with tone=0 followed by the first toggle after TONE_HALF cycles.
- done and busy are registered. On the edge returning to IDLE from END, done=1 and busy=0 in the same cycle.

Decomposition:
- Package meriac_morse_pkg:
  - symbol code constants (SYM_END, SYM_DIT, SYM_DAH, SYM_GAP);
  - the state enum;
  - unit-length constants (DIT_UNITS=1, DAH_UNITS=3, ELEM_GAP_UNITS=1, GAP_UNITS=2, LOOP_GAP_UNITS=7).
- Sub-module meriac_morse_unit_timer: prescaler plus unit down-counter with a load input and a one-cycle expiry pulse. The sequencer FSM and the tone divider remain in the top module.

Test Plan:
- Reset: hold reset=0, toggle clk, then assert reset=0 asynchronously mid-MARK -> key, tone, busy, done and db_addr go to 0 immediately; after release, state is IDLE.
- Single DIT with UNIT_CYCLES=4, ROM {01,00}, loop_en=0, start pulse -> key=1 for exactly 4 cycles, then 4 cycles low, then 1 FETCH cycle. Then done=1 for one cycle with busy=0, and db_addr=0.
- DAH plus GAP with ROM {10,11,01,00} -> key high 12 cycles, low 4+8=12 cycles (plus FETCH cycles), high 4 cycles. db_addr sequence 0,1,2,3.
- Loop with ROM {01,00}, loop_en=1 -> key high 4 cycles, low 4+28 cycles (plus FETCH cycles), then repeats. done is never asserted and db_addr returns to 0.
- Stop and start priority:
  - stop mid-MARK -> key=0 on the next edge, busy=0, done=0.
  - start and stop asserted together in IDLE -> stays IDLE.
  - start while busy -> no restart (db_addr continues).
- Tone with TONE_HALF=2 during a 12-cycle DAH -> tone sequence 0,0,1,1,0,0,1,1,0,0,1,1. tone=0 throughout SPACE.

Source files
------------

// File: rtl/meriac_morse_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// meriac_morse_pkg : shared symbol codes, FSM states and unit lengths.  Rev 1.0
// ----------------------------------------------------------------------------
package meriac_morse_pkg;

   localparam logic [1:0] SYM_END = 2'b00;
   localparam logic [1:0] SYM_DIT = 2'b01;
   localparam logic [1:0] SYM_DAH = 2'b10;
   localparam logic [1:0] SYM_GAP = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_MARK  = 2'd2,
      ST_SPACE = 2'd3
   } state_t;

   localparam int UNITS_W = 3;

   localparam logic [UNITS_W-1:0] DIT_UNITS      = 3'd1;
   localparam logic [UNITS_W-1:0] DAH_UNITS      = 3'd3;
   localparam logic [UNITS_W-1:0] ELEM_GAP_UNITS = 3'd1;
   localparam logic [UNITS_W-1:0] GAP_UNITS      = 3'd2;
   localparam logic [UNITS_W-1:0] LOOP_GAP_UNITS = 3'd7;

endpackage
`default_nettype wire

// File: rtl/meriac_morse_unit_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// meriac_morse_unit_timer : prescaler + unit down-counter, expiry pulse.  Rev 1.0
// ----------------------------------------------------------------------------
module meriac_morse_unit_timer
   import meriac_morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 5424
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_clr,
   input  logic               i_load,
   input  logic [UNITS_W-1:0] i_units,
   output logic               o_expire
);

   localparam int                 c_PRE_W   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(UNIT_CYCLES - 1);

   logic [c_PRE_W-1:0] r_pre;
   logic [UNITS_W-1:0] r_units;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre   <= '0;
         r_units <= '0;
      end else if (i_clr) begin
         r_pre   <= '0;
         r_units <= '0;
      end else if (i_load) begin
         r_pre   <= '0;
         r_units <= i_units;
      end else if (r_units != '0) begin
         if (r_pre == c_PRE_MAX) begin
            r_pre   <= '0;
            r_units <= r_units - UNITS_W'(1);
         end else begin
            r_pre <= r_pre + c_PRE_W'(1);
         end
      end
   end

   // Fires on the final cycle of the last unit, so an n-unit load spans n*UNIT_CYCLES cycles.
   assign o_expire = (r_units == UNITS_W'(1)) && (r_pre == c_PRE_MAX);

endmodule
`default_nettype wire

// File: rtl/meriac_morse_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// meriac_morse_sequencer : Morse symbol playback FSM with gated tone.  Rev 1.0
// ----------------------------------------------------------------------------
module meriac_morse_sequencer
   import meriac_morse_pkg::*;
#(
   parameter int ADDR_W      = 9,
   parameter int UNIT_CYCLES = 5424,
   parameter int TONE_HALF   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] db_addr,
   input  logic [1:0]        db_sym,
   output logic              key,
   output logic              tone,
   output logic              busy,
   output logic              done
);

   localparam int                  c_TONE_W   = $clog2(TONE_HALF + 1);
   localparam logic [c_TONE_W-1:0] c_TONE_MAX = c_TONE_W'(TONE_HALF - 1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_db_addr;
   logic                r_key;
   logic                r_busy;
   logic                r_done;
   logic [c_TONE_W-1:0] r_div;
   logic                r_tone;

   logic                w_load;
   logic [UNITS_W-1:0]  w_units;
   logic                w_expire;

   // Timer load decode must coincide with the state transition edge.
   always_comb begin
      w_load  = 1'b0;
      w_units = '0;
      case (r_state)
         ST_FETCH: begin
            case (db_sym)
               SYM_DIT: begin w_load = 1'b1; w_units = DIT_UNITS; end
               SYM_DAH: begin w_load = 1'b1; w_units = DAH_UNITS; end
               SYM_GAP: begin w_load = 1'b1; w_units = GAP_UNITS; end
               default: begin
                  w_load  = loop_en;
                  w_units = LOOP_GAP_UNITS;
               end
            endcase
         end
         ST_MARK: begin
            w_load  = w_expire;
            w_units = ELEM_GAP_UNITS;
         end
         default: ;
      endcase
   end

   meriac_morse_unit_timer #(
      .UNIT_CYCLES(UNIT_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst_n    (reset),
      .i_clr    (stop),
      .i_load   (w_load),
      .i_units  (w_units),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_db_addr <= '0;
         r_key     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else if (stop) begin
         r_state   <= ST_IDLE;
         r_db_addr <= '0;
         r_key     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_FETCH;
                  r_busy    <= 1'b1;
                  r_db_addr <= '0;
               end
            end
            ST_FETCH: begin
               case (db_sym)
                  SYM_DIT, SYM_DAH: begin
                     r_state <= ST_MARK;
                     r_key   <= 1'b1;
                  end
                  SYM_GAP: begin
                     r_state   <= ST_SPACE;
                     r_db_addr <= r_db_addr + ADDR_W'(1);
                  end
                  default: begin
                     r_db_addr <= '0;
                     if (loop_en) begin
                        r_state <= ST_SPACE;
                     end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  end
               endcase
            end
            ST_MARK: begin
               if (w_expire) begin
                  r_state   <= ST_SPACE;
                  r_key     <= 1'b0;
                  r_db_addr <= r_db_addr + ADDR_W'(1);
               end
            end
            ST_SPACE: begin
               if (w_expire) begin
                  r_state <= ST_FETCH;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Divider idles at zero between marks so every mark opens with a full low half-period.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div  <= '0;
         r_tone <= 1'b0;
      end else if (!r_key) begin
         r_div  <= '0;
         r_tone <= 1'b0;
      end else if (r_div == c_TONE_MAX) begin
         r_div  <= '0;
         r_tone <= ~r_tone;
      end else begin
         r_div <= r_div + c_TONE_W'(1);
      end
   end

   assign db_addr = r_db_addr;
   assign key     = r_key;
   assign tone    = r_tone & r_key;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_meriac_morse_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_meriac_morse_sequencer : table + scoreboard bench for the sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_meriac_morse_sequencer;
   import meriac_morse_pkg::*;

   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int UC    = 4;
   localparam int TH    = 2;

   logic          clk     = 1'b0;
   logic          reset   = 1'b0;
   logic          start   = 1'b0;
   logic          stop    = 1'b0;
   logic          loop_en = 1'b0;
   logic [AW-1:0] db_addr;
   logic [1:0]    db_sym;
   logic          key, tone, busy, done;
   logic [15:0]   rom_bits = '0;

   assign db_sym = rom_bits[int'(db_addr)*2 +: 2];

   always #5 clk = ~clk;

   meriac_morse_sequencer #(
      .ADDR_W      (AW),
      .UNIT_CYCLES (UC),
      .TONE_HALF   (TH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .stop    (stop),
      .loop_en (loop_en),
      .db_addr (db_addr),
      .db_sym  (db_sym),
      .key     (key),
      .tone    (tone),
      .busy    (busy),
      .done    (done)
   );

   typedef struct packed {
      logic          key;
      logic          tone;
      logic          busy;
      logic          done;
      logic [AW-1:0] addr;
   } obs_t;

   typedef struct {
      string       name;
      logic [15:0] rom;
      logic        loop;
      int          limit;
      int          restart_at;
      logic        exp_done;
   } vec_t;

   obs_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t vecs[6];

   function automatic logic [15:0] mk(input logic [1:0] s0, s1, s2, s3, s4, s5, s6, s7);
      return {s7, s6, s5, s4, s3, s2, s1, s0};
   endfunction

   function automatic obs_t mko(input logic k, t, b, d, input int a);
      obs_t o;
      o.key = k; o.tone = t; o.busy = b; o.done = d; o.addr = AW'(a);
      return o;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.key = key; o.tone = tone; o.busy = busy; o.done = done; o.addr = db_addr;
      return o;
   endfunction

   task automatic check(input string nm, input obs_t act, input obs_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got key=%b tone=%b busy=%b done=%b addr=%0d, want key=%b tone=%b busy=%b done=%b addr=%0d",
                    nm, act.key, act.tone, act.busy, act.done, act.addr,
                    exp.key, exp.tone, exp.busy, exp.done, exp.addr);
   endtask

   task automatic push(input obs_t e, input int limit);
      if (sb.size() < limit) sb.push_back(e);
   endtask

   // Reference model: expected per-cycle outputs from the FETCH cycle onward.
   task automatic build(input vec_t v);
      int         addr = 0;
      bit         fin  = 1'b0;
      logic [1:0] s;
      sb.delete();
      push(mko(0, 0, 1, 0, addr), v.limit);
      while (!fin && sb.size() < v.limit) begin
         s = v.rom[addr*2 +: 2];
         if (s == SYM_DIT || s == SYM_DAH) begin
            int n = (s == SYM_DIT) ? 1 : 3;
            for (int j = 0; j < n*UC; j++) push(mko(1, 1'((j / TH) % 2), 1, 0, addr), v.limit);
            addr = (addr + 1) % DEPTH;
            for (int j = 0; j < UC; j++) push(mko(0, 0, 1, 0, addr), v.limit);
         end else if (s == SYM_GAP) begin
            addr = (addr + 1) % DEPTH;
            for (int j = 0; j < 2*UC; j++) push(mko(0, 0, 1, 0, addr), v.limit);
         end else if (v.loop) begin
            addr = 0;
            for (int j = 0; j < 7*UC; j++) push(mko(0, 0, 1, 0, addr), v.limit);
         end else begin
            push(mko(0, 0, 0, 1, 0), v.limit);
            push(mko(0, 0, 0, 0, 0), v.limit);
            fin = 1'b1;
         end
         if (!fin) push(mko(0, 0, 1, 0, addr), v.limit);
      end
   endtask

   task automatic run_vec(input vec_t v);
      bit   seen_done = 1'b0;
      obs_t a, e;
      int   k = 0;
      build(v);
      @(negedge clk);
      rom_bits = v.rom;
      loop_en  = v.loop;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         a = observe();
         if (a.done) seen_done = 1'b1;
         check($sformatf("%s cyc%0d", v.name, k), a, e);
         start = (k == v.restart_at);
         k++;
         @(negedge clk);
      end
      start = 1'b0;
      stop  = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check({v.name, " after stop"}, observe(), mko(0, 0, 0, 0, 0));
      n_checks++;
      if (seen_done === v.exp_done) n_pass++;
      else $display("FAIL %s done_seen: got %b, want %b", v.name, seen_done, v.exp_done);
   endtask

   initial begin
      vecs[0] = '{"dit",       mk(SYM_DIT, SYM_END, SYM_END, SYM_END, SYM_END, SYM_END, SYM_END, SYM_END), 1'b0, 1000, -1, 1'b1};
      vecs[1] = '{"dah_gap",   mk(SYM_DAH, SYM_GAP, SYM_DIT, SYM_END, SYM_END, SYM_END, SYM_END, SYM_END), 1'b0, 1000,  5, 1'b1};
      vecs[2] = '{"loop",      mk(SYM_DIT, SYM_END, SYM_END, SYM_END, SYM_END, SYM_END, SYM_END, SYM_END), 1'b1,   80, -1, 1'b0};
      vecs[3] = '{"word_gap",  mk(SYM_DAH, SYM_GAP, SYM_GAP, SYM_GAP, SYM_DIT, SYM_END, SYM_END, SYM_END), 1'b0, 1000, -1, 1'b1};
      vecs[4] = '{"wrap",      mk(SYM_DIT, SYM_DIT, SYM_DIT, SYM_DIT, SYM_DIT, SYM_DIT, SYM_DIT, SYM_DIT), 1'b0,   80, 30, 1'b0};
      vecs[5] = '{"stop_mark", mk(SYM_DAH, SYM_END, SYM_END, SYM_END, SYM_END, SYM_END, SYM_END, SYM_END), 1'b0,    6, -1, 1'b0};

      repeat (3) @(negedge clk);
      check("reset hold", observe(), mko(0, 0, 0, 0, 0));
      reset = 1'b1;
      @(negedge clk);
      check("post reset idle", observe(), mko(0, 0, 0, 0, 0));

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // start and stop together: stop wins, stays idle
      @(negedge clk);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      check("start+stop", observe(), mko(0, 0, 0, 0, 0));
      @(negedge clk);
      check("start+stop hold", observe(), mko(0, 0, 0, 0, 0));

      // asynchronous reset in the middle of a mark at a nonzero address
      rom_bits = mk(SYM_GAP, SYM_DIT, SYM_END, SYM_END, SYM_END, SYM_END, SYM_END, SYM_END);
      loop_en  = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && !key; i++) @(negedge clk);
      check("reach mark", observe(), mko(1, 0, 1, 0, 1));
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 check("async reset", observe(), mko(0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("idle after async reset", observe(), mko(0, 0, 0, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
